// File: rtl/ser_pkg.sv
// Shared definitions for the serial frame feeder: sample width, frame length
// and the feeder FSM state encoding.
package ser_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int FRAME_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2,
        SEND3 = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/ser_frame_feeder_if.sv
// Upstream sample stream plus averager-side signals of the frame feeder.
// The master is the environment (source and averager); the slave is the feeder.
interface ser_frame_feeder_if #(
    parameter int SAMPLE_W = ser_pkg::SAMPLE_W
);

    logic [SAMPLE_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic                done;
    logic [SAMPLE_W-1:0] ser_out;
    logic                frame_valid;
    logic [7:0]          skip_cnt;

    modport master (
        output in_data, in_valid, done,
        input  in_ready, ser_out, frame_valid, skip_cnt
    );

    modport slave (
        input  in_data, in_valid, done,
        output in_ready, ser_out, frame_valid, skip_cnt
    );

endinterface

// File: rtl/sample_fifo.sv
// Sample buffer for the frame feeder: registered storage, combinational head,
// occupancy count one bit wider than the pointers.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is never reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ser_frame_feeder.sv
// Feeds the averager's serial input in 4-sample frames, launching a frame only
// when every sample of it is already buffered; counts frames that had to be skipped.
//
// state | meaning
// IDLE  | no frame in flight; on done either launch (>=4 buffered) or count a skip
// SEND1 | second sample of the frame on ser_out
// SEND2 | third sample of the frame on ser_out
// SEND3 | last sample of the frame on ser_out
module ser_frame_feeder
    import ser_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SAMPLE_W = ser_pkg::SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst,
    ser_frame_feeder_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SEND1 = SEND1;
    localparam logic [1:0] ST_SEND2 = SEND2;
    localparam logic [1:0] ST_SEND3 = SEND3;

    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic [SAMPLE_W-1:0] head;
    logic [7:0]          skip_q;
    logic                launch;
    logic                skip;
    logic                pop;
    logic                push;

    assign launch = !rst && (state == ST_IDLE) && bus.done && (count >= FRAME_CNT);
    assign skip   = (state == ST_IDLE) && bus.done && (count < FRAME_CNT);
    // Once launched, the remaining three samples are guaranteed buffered.
    assign pop    = launch || (!rst && (state != ST_IDLE));
    assign push   = bus.in_valid && bus.in_ready;

    assign bus.in_ready    = !rst && ((count < FULL_CNT) || pop);
    assign bus.frame_valid = pop;
    assign bus.ser_out     = pop ? head : '0;
    assign bus.skip_cnt    = skip_q;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.in_data),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= launch ? ST_SEND1 : ST_IDLE;
                ST_SEND1: state <= ST_SEND2;
                ST_SEND2: state <= ST_SEND3;
                ST_SEND3: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= '0;
        end else if (skip && (skip_q != 8'hFF)) begin
            skip_q <= skip_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_ser_frame_feeder.sv
// Randomised checks of ser_frame_feeder against a queue-based frame model.
module tb_ser_frame_feeder;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ser_frame_feeder_if #(.SAMPLE_W(8)) bus ();

    ser_frame_feeder #(.DEPTH(DEPTH), .SAMPLE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: buffered samples, samples still owed to the current frame, skips
    logic [7:0] q[$];
    int         remain = 0;
    int         skips  = 0;

    logic       exp_ready, exp_valid, exp_pop;
    logic [7:0] exp_ser, exp_skip;
    logic       obs_ready, obs_valid;
    logic [7:0] obs_ser, obs_skip;

    task automatic run_cycle(input logic r, input logic [7:0] d, input logic v, input logic dn);
        rst          = r;
        bus.in_data  = d;
        bus.in_valid = v;
        bus.done     = dn;
        @(negedge clk);
        if (r) begin
            exp_pop   = 1'b0;
            exp_ready = 1'b0;
        end else begin
            exp_pop   = (remain > 0) || (dn && q.size() >= 4);
            exp_ready = (q.size() < DEPTH) || exp_pop;
        end
        exp_valid = exp_pop;
        exp_ser   = exp_pop ? q[0] : 8'd0;
        exp_skip  = 8'(skips);
        obs_ready = bus.in_ready;
        obs_valid = bus.frame_valid;
        obs_ser   = bus.ser_out;
        obs_skip  = bus.skip_cnt;
        @(posedge clk);
        if (r) begin
            q.delete();
            remain = 0;
            skips  = 0;
        end else begin
            if (exp_pop) begin
                void'(q.pop_front());
                remain = (remain > 0) ? remain - 1 : 3;
            end else if (dn && skips < 255) begin
                skips++;
            end
            if (v && exp_ready) q.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset();
        run_cycle(1'b1, 8'd0, 1'b0, 1'b0);
        run_cycle(1'b1, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({obs_ready, obs_valid, obs_ser, obs_skip} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b ser=%0d skip=%0d want rdy=1 vld=0 ser=0 skip=0",
                     obs_ready, obs_valid, obs_ser, obs_skip);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int sum = 0;
        do_reset();
        for (int i = 0; i < 4; i++) run_cycle(1'b0, vals[i], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 8'd0, 1'b0, (i == 0));
            total++;
            if ({obs_valid, obs_ser} !== {1'b1, vals[i]}) begin
                bad++;
                $display("FAIL basic_frame[%0d]: got vld=%b ser=%0d want vld=1 ser=%0d",
                         i, obs_valid, obs_ser, vals[i]);
            end
            sum += int'(obs_ser);
        end
        total++;
        if (sum / 4 !== 25) begin
            bad++;
            $display("FAIL basic_average: got %0d want 25", sum / 4);
        end
    endtask

    task automatic test_skip();
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'(50 + i), 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            run_cycle(1'b0, 8'd0, 1'b0, (i % 4 == 0) && (i < 8));
            total++;
            if ({obs_ready, obs_valid, obs_ser, obs_skip} !== {exp_ready, exp_valid, exp_ser, exp_skip}) begin
                bad++;
                $display("FAIL skip_frames cyc%0d: got rdy=%b vld=%b ser=%0d skip=%0d want rdy=%b vld=%b ser=%0d skip=%0d",
                         i, obs_ready, obs_valid, obs_ser, obs_skip, exp_ready, exp_valid, exp_ser, exp_skip);
            end
        end
        total++;
        if (obs_skip !== 8'd2) begin
            bad++;
            $display("FAIL skip_count: got %0d want 2", obs_skip);
        end
        // one more sample must complete a frame from the three retained ones
        run_cycle(1'b0, 8'd53, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 8'd0, 1'b0, (i == 0));
            total++;
            if ({obs_valid, obs_ser} !== {1'b1, 8'(50 + i)}) begin
                bad++;
                $display("FAIL skip_retained[%0d]: got vld=%b ser=%0d want vld=1 ser=%0d",
                         i, obs_valid, obs_ser, 50 + i);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        run_cycle(1'b0, 8'hEE, 1'b1, 1'b0);
        total++;
        if (obs_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_blocks: got rdy=%b want rdy=0", obs_ready);
        end
        run_cycle(1'b0, 8'hA5, 1'b1, 1'b1);
        total++;
        if ({obs_ready, obs_valid} !== 2'b11) begin
            bad++;
            $display("FAIL full_pop_push: got rdy=%b vld=%b want rdy=1 vld=1", obs_ready, obs_valid);
        end
        for (int i = 1; i < 13; i++) begin
            run_cycle(1'b0, 8'd0, 1'b0, (i % 4 == 0));
            total++;
            if ({obs_ready, obs_valid, obs_ser, obs_skip} !== {exp_ready, exp_valid, exp_ser, exp_skip}) begin
                bad++;
                $display("FAIL full_drain cyc%0d: got rdy=%b vld=%b ser=%0d skip=%0d want rdy=%b vld=%b ser=%0d skip=%0d",
                         i, obs_ready, obs_valid, obs_ser, obs_skip, exp_ready, exp_valid, exp_ser, exp_skip);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 8'(100 + i), 1'b1, 1'b0);
        run_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        run_cycle(1'b1, 8'd0, 1'b0, 1'b0);
        run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({obs_valid, obs_skip, obs_ready} !== {1'b0, 8'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_after: got vld=%b skip=%0d rdy=%b want vld=0 skip=0 rdy=1",
                     obs_valid, obs_skip, obs_ready);
        end
        run_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({obs_valid, obs_skip} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL reset_mid_flush: got vld=%b skip=%0d want vld=0 skip=1", obs_valid, obs_skip);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            run_cycle(1'b0, 8'd0, 1'b0, (i % 4 == 0));
            total++;
            if ({obs_valid, obs_ser, obs_skip} !== {exp_valid, exp_ser, exp_skip}) begin
                bad++;
                $display("FAIL saturate cyc%0d: got vld=%b ser=%0d skip=%0d want vld=%b ser=%0d skip=%0d",
                         i, obs_valid, obs_ser, obs_skip, exp_valid, exp_ser, exp_skip);
            end
        end
        run_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        total++;
        if (obs_skip !== 8'd255) begin
            bad++;
            $display("FAIL saturate_final: got skip=%0d want 255", obs_skip);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            run_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b1, (i >= 4) && (i % 4 == 0));
            total++;
            if ({obs_ready, obs_valid, obs_ser, obs_skip} !== {1'b1, exp_valid, exp_ser, 8'd0} ||
                (i >= 4 && obs_valid !== 1'b1)) begin
                bad++;
                $display("FAIL stream cyc%0d: got rdy=%b vld=%b ser=%0d skip=%0d want rdy=1 vld=%b ser=%0d skip=0",
                         i, obs_ready, obs_valid, obs_ser, obs_skip, exp_valid, exp_ser);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            run_cycle(($urandom_range(0, 199) == 0), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
            total++;
            if ({obs_ready, obs_valid, obs_ser, obs_skip} !== {exp_ready, exp_valid, exp_ser, exp_skip}) begin
                bad++;
                $display("FAIL random cyc%0d: got rdy=%b vld=%b ser=%0d skip=%0d want rdy=%b vld=%b ser=%0d skip=%0d",
                         i, obs_ready, obs_valid, obs_ser, obs_skip, exp_ready, exp_valid, exp_ser, exp_skip);
            end
        end
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        test_reset();
        test_basic();
        test_skip();
        test_full();
        test_reset_mid();
        test_saturate();
        test_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser_frame_feeder.md
SER_FRAME_FEEDER -- requirements
Module: ser_frame_feeder

Interface
REQ-001 Parameter: DEPTH, 8, FIFO depth in samples; SHALL be a power of two and at least 4.
REQ-002 Parameter: SAMPLE_W, 8, sample width in bits; SHALL match the averager's ser_in width.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  SAMPLE_W  upstream sample.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  feeder can accept a sample this cycle.
REQ-008 Port: done  input  1  averager's frame-start indicator; high in the cycle the averager latches sample 0.
REQ-009 Port: ser_out  output  SAMPLE_W  sample presented to the averager's ser_in.
REQ-010 Port: frame_valid  output  1  ser_out carries a real sample of the current frame.
REQ-011 Port: skip_cnt  output  8  saturating count of averager frames started without data.

Function
REQ-012 A push SHALL occur when in_valid && in_ready; in_ready SHALL equal (count < DEPTH) || pop_this_cycle.
REQ-013 Simultaneous push and pop SHALL leave count unchanged; at full with a pop, the push SHALL be accepted.
REQ-014 The averager consumes one sample per cycle unconditionally, in frames of 4 (FRAME_LEN) starting on done=1; the feeder SHALL only launch a frame when all 4 samples are already buffered.
REQ-015 FSM states: IDLE, SEND1, SEND2, SEND3.
REQ-016 IDLE: if done=1 and count>=4, pop the head, drive it on ser_out, assert frame_valid, and go to SEND1.
REQ-017 IDLE: if done=1 and count<4, pop nothing, drive ser_out=0, hold frame_valid=0, increment skip_cnt (saturate at 255), and stay in IDLE.
REQ-018 IDLE with done=0: ser_out=0, frame_valid=0, and no pop.
REQ-019 SEND1/SEND2/SEND3: pop unconditionally, drive the head on ser_out, and assert frame_valid; advance SEND1->SEND2->SEND3->IDLE regardless of done.
REQ-020 ser_out and frame_valid SHALL be combinational from the FIFO head and the FSM state (zero latency), so the sample is stable before the edge at which the averager latches it.
REQ-021 Samples SHALL leave in arrival order; no sample is ever dropped or duplicated.
REQ-022 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-023 Pushes during SEND states are legal; a frame already launched SHALL never underrun.

Reset
REQ-024 On rst=1: FSM to IDLE; pointers, count, and skip_cnt to 0; ser_out=0; frame_valid=0; in_ready=1 from the first cycle after reset.
REQ-025 Reset mid-frame SHALL abort the frame and flush all buffered samples; this is consistent with the averager returning to its frame-start state on the same rst.

Structure
REQ-026 Shared package ser_pkg SHALL hold SAMPLE_W, FRAME_LEN=4, and the feeder FSM state enum.
REQ-027 Storage SHALL be a sub-module sample_fifo (push/pop/head/count); the FSM and skip counter live in ser_frame_feeder.

Verification
REQ-028 Reset, then push 10,20,30,40 back-to-back: at the next done=1 cycle, ser_out SHALL be 10,20,30,40 on 4 consecutive cycles with frame_valid=1, and the averager's average SHALL be 25.
REQ-029 Push only 3 samples, then run 2 averager frames: ser_out=0, frame_valid=0, skip_cnt=2, and count stays 3.
REQ-030 Push 8 samples with no done: in_ready=0 and a ninth push is ignored; then, while done=1 with a ninth sample offered, the push SHALL be accepted and count stays 8.
REQ-031 Assert rst in SEND2 of a frame: the next cycle, frame_valid=0, count=0, and skip_cnt=0; the following frame is skipped if no new data arrives.
REQ-032 Hold the FIFO empty for 300 frames: skip_cnt SHALL saturate at 255.
REQ-033 Continuous stream of 1 sample/cycle starting before the first done: every frame valid, skip_cnt=0, and in_ready stays 1.
